// File: rtl/pulse_seq_pkg.sv
// Shared constants for the multi-pulse sequencer: register map, reset
// defaults and the per-window address decode helper.
`timescale 1ns/1ps
package pulse_seq_pkg;

    // Register map
    localparam logic [7:0] ADDR_PERIOD    = 8'h00;
    localparam logic [7:0] ADDR_NPULSE    = 8'h01;
    localparam logic [7:0] ADDR_CTRL      = 8'h02;
    localparam logic [7:0] ADDR_ATT_PROBE = 8'h03;
    localparam logic [7:0] ADDR_ATT_PUMP  = 8'h04;
    localparam logic [7:0] ADDR_WIN_BASE  = 8'h10;
    localparam logic [7:0] ADDR_COMMIT    = 8'hFF;

    // Reset defaults, shared by the shadow and active copies
    localparam int DEF_PERIOD    = 200000;
    localparam int DEF_NPULSE    = 2;
    localparam int DEF_START0    = 0;
    localparam int DEF_WIDTH0    = 30;
    localparam int DEF_START1    = 230;
    localparam int DEF_WIDTH1    = 30;
    localparam int DEF_ALT_EN    = 1;
    localparam int DEF_ATT_PROBE = 127;
    localparam int DEF_ATT_PUMP  = 0;
    localparam int DEF_END0      = DEF_START0 + DEF_WIDTH0;
    localparam int DEF_END1      = DEF_START1 + DEF_WIDTH1;
    localparam int DEF_SYNC_END  = (DEF_END1 > DEF_END0) ? DEF_END1 : DEF_END0;

    // Decoded window address: 0x10+2k is start[k], 0x11+2k is width[k]
    typedef struct packed {
        logic       hit;
        logic       is_width;
        logic [2:0] idx;
    } win_addr_t;

    function automatic win_addr_t decode_win_addr(input logic [7:0] addr);
        win_addr_t r;
        r.hit      = (addr[7:4] == 4'h1);
        r.is_width = addr[0];
        r.idx      = addr[3:1];
        return r;
    endfunction

endpackage

// File: rtl/pulse_window.sv
// One programmable pulse window: active while start <= cnt < start+width.
// The end is formed one bit wider than the counter so it cannot wrap.
`timescale 1ns/1ps
module pulse_window #(
    parameter int CW = 32
) (
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] start,
    input  logic [CW-1:0] width,
    input  logic          en,
    output logic          active
);

    logic [CW:0] end_s;

    // Window membership test on the widened end value
    always_comb begin
        end_s  = {1'b0, start} + {1'b0, width};
        active = en && ({1'b0, cnt} >= {1'b0, start}) && ({1'b0, cnt} < end_s);
    end

endmodule

// File: rtl/multi_pulse_seq.sv
// N-pulse pump/probe sequencer. A shadow register file is written by the
// command decoder; a commit copies it into the active set at the next period
// wrap so a period in progress is never disturbed.
`timescale 1ns/1ps
module multi_pulse_seq
    import pulse_seq_pkg::*;
#(
    parameter int NPULSE     = 4,
    parameter int CW         = 32,
    parameter int ATT_W      = 7,
    parameter int ATT_DLY    = 20000,
    // Period loaded at reset; shortened only for quick simulation runs
    parameter int RST_PERIOD = DEF_PERIOD
) (
    input  logic             clk_pll,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [7:0]       cfg_addr,
    input  logic [CW-1:0]    cfg_data,
    output logic             pulse,
    output logic             sync,
    output logic             pump_on,
    output logic [ATT_W-1:0] att,
    output logic             cycle_start,
    output logic             cfg_pending
);

    // Shadow copies
    logic [CW-1:0]    sh_period_r;
    logic [3:0]       sh_npulse_r;
    logic             sh_alt_en_r;
    logic [ATT_W-1:0] sh_att_probe_r;
    logic [ATT_W-1:0] sh_att_pump_r;
    logic [CW-1:0]    sh_start_r [NPULSE];
    logic [CW-1:0]    sh_width_r [NPULSE];

    // Active copies
    logic [CW-1:0]    act_period_r;
    logic [3:0]       act_npulse_r;
    logic             act_alt_en_r;
    logic [ATT_W-1:0] act_att_probe_r;
    logic [ATT_W-1:0] act_att_pump_r;
    logic [CW-1:0]    act_start_r [NPULSE];
    logic [CW-1:0]    act_width_r [NPULSE];
    logic [CW:0]      act_sync_end_r;
    logic [CW+1:0]    act_att_end_r;
    logic [CW:0]      act_end0_r;

    logic [CW-1:0]    cnt_r;
    logic             pending_r;
    logic             pump_r;

    win_addr_t        win_s;
    logic             commit_s;
    logic [CW-1:0]    period_eff_s;
    logic             wrap_s;
    logic             apply_s;
    logic             next_alt_s;
    logic [3:0]       npulse_sat_s;
    logic [CW:0]      sh_end_s [NPULSE];
    logic [CW:0]      sh_sync_end_s;
    logic [CW+1:0]    sh_att_end_s;
    logic [NPULSE-1:0] win_en_s;
    logic [NPULSE-1:0] win_act_s;
    logic [NPULSE-1:0] win_gated_s;
    logic             pulse_nxt_s;
    logic [ATT_W-1:0] att_nxt_s;

    assign cfg_pending = pending_r;

    // Write decode, wrap detection and apply condition
    always_comb begin
        win_s        = decode_win_addr(cfg_addr);
        commit_s     = cfg_wr && (cfg_addr == ADDR_COMMIT);
        period_eff_s = (act_period_r < CW'(2)) ? CW'(2) : act_period_r;
        wrap_s       = (cnt_r >= (period_eff_s - CW'(1)));
        // A commit arriving on the wrap cycle itself is applied immediately
        apply_s      = wrap_s && (pending_r || commit_s);
        next_alt_s   = apply_s ? sh_alt_en_r : act_alt_en_r;
        if (cfg_data > CW'(NPULSE)) begin
            npulse_sat_s = 4'(NPULSE);
        end else begin
            npulse_sat_s = cfg_data[3:0];
        end
    end

    // Window end sums from the shadow set, widened so they never overflow
    always_comb begin
        for (int k = 0; k < NPULSE; k++) begin
            sh_end_s[k] = {1'b0, sh_start_r[k]} + {1'b0, sh_width_r[k]};
        end
    end

    // Latest end over enabled, non-empty shadow windows; drives sync and att
    always_comb begin
        sh_sync_end_s = '0;
        for (int k = 0; k < NPULSE; k++) begin
            if ((4'(k) < sh_npulse_r) && (sh_width_r[k] != '0) &&
                (sh_end_s[k] > sh_sync_end_s)) begin
                sh_sync_end_s = sh_end_s[k];
            end else begin
                sh_sync_end_s = sh_sync_end_s;
            end
        end
        sh_att_end_s = {1'b0, sh_sync_end_s} + (CW+2)'(ATT_DLY);
    end

    // Shadow register file
    always_ff @(posedge clk_pll) begin
        if (rst) begin
            sh_period_r    <= CW'(RST_PERIOD);
            sh_npulse_r    <= 4'(DEF_NPULSE);
            sh_alt_en_r    <= 1'(DEF_ALT_EN);
            sh_att_probe_r <= ATT_W'(DEF_ATT_PROBE);
            sh_att_pump_r  <= ATT_W'(DEF_ATT_PUMP);
            for (int k = 0; k < NPULSE; k++) begin
                sh_start_r[k] <= (k == 1) ? CW'(DEF_START1) : CW'(DEF_START0);
                sh_width_r[k] <= (k == 0) ? CW'(DEF_WIDTH0) :
                                 (k == 1) ? CW'(DEF_WIDTH1) : CW'(0);
            end
        end else if (cfg_wr) begin
            case (cfg_addr)
                ADDR_PERIOD:    sh_period_r    <= cfg_data;
                ADDR_NPULSE:    sh_npulse_r    <= npulse_sat_s;
                ADDR_CTRL:      sh_alt_en_r    <= cfg_data[0];
                ADDR_ATT_PROBE: sh_att_probe_r <= cfg_data[ATT_W-1:0];
                ADDR_ATT_PUMP:  sh_att_pump_r  <= cfg_data[ATT_W-1:0];
                ADDR_COMMIT:    begin end
                default: begin
                    for (int k = 0; k < NPULSE; k++) begin
                        if (win_s.hit && (win_s.idx == 3'(k))) begin
                            if (win_s.is_width) begin
                                sh_width_r[k] <= cfg_data;
                            end else begin
                                sh_start_r[k] <= cfg_data;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Period counter, commit tracking, active-set load and pump alternation
    always_ff @(posedge clk_pll) begin
        if (rst) begin
            cnt_r           <= '0;
            pending_r       <= 1'b0;
            pump_r          <= 1'b1;
            act_period_r    <= CW'(RST_PERIOD);
            act_npulse_r    <= 4'(DEF_NPULSE);
            act_alt_en_r    <= 1'(DEF_ALT_EN);
            act_att_probe_r <= ATT_W'(DEF_ATT_PROBE);
            act_att_pump_r  <= ATT_W'(DEF_ATT_PUMP);
            act_sync_end_r  <= (CW+1)'(DEF_SYNC_END);
            act_att_end_r   <= (CW+2)'(DEF_SYNC_END) + (CW+2)'(ATT_DLY);
            act_end0_r      <= (CW+1)'(DEF_END0);
            for (int k = 0; k < NPULSE; k++) begin
                act_start_r[k] <= (k == 1) ? CW'(DEF_START1) : CW'(DEF_START0);
                act_width_r[k] <= (k == 0) ? CW'(DEF_WIDTH0) :
                                  (k == 1) ? CW'(DEF_WIDTH1) : CW'(0);
            end
        end else begin
            cnt_r <= wrap_s ? '0 : cnt_r + CW'(1);
            if (wrap_s) begin
                pump_r <= next_alt_s ? ~pump_r : 1'b1;
            end
            if (apply_s) begin
                pending_r       <= 1'b0;
                act_period_r    <= sh_period_r;
                act_npulse_r    <= sh_npulse_r;
                act_alt_en_r    <= sh_alt_en_r;
                act_att_probe_r <= sh_att_probe_r;
                act_att_pump_r  <= sh_att_pump_r;
                act_sync_end_r  <= sh_sync_end_s;
                act_att_end_r   <= sh_att_end_s;
                act_end0_r      <= sh_end_s[0];
                for (int k = 0; k < NPULSE; k++) begin
                    act_start_r[k] <= sh_start_r[k];
                    act_width_r[k] <= sh_width_r[k];
                end
            end else if (commit_s) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Per-window comparators on the active set
    for (genvar k = 0; k < NPULSE; k++) begin : g_win
        assign win_en_s[k] = (4'(k) < act_npulse_r);
        pulse_window #(.CW(CW)) u_win (
            .cnt    (cnt_r),
            .start  (act_start_r[k]),
            .width  (act_width_r[k]),
            .en     (win_en_s[k]),
            .active (win_act_s[k])
        );
    end

    // Pump gating of window 0 and attenuator selection
    always_comb begin
        win_gated_s    = win_act_s;
        win_gated_s[0] = win_act_s[0] && !(act_alt_en_r && !pump_r);
        pulse_nxt_s    = |win_gated_s;
        if (({2'b00, cnt_r} >= {1'b0, act_end0_r}) &&
            ({2'b00, cnt_r} < act_att_end_r)) begin
            att_nxt_s = act_att_probe_r;
        end else begin
            att_nxt_s = act_att_pump_r;
        end
    end

    // Output registers: one cycle behind the counter
    always_ff @(posedge clk_pll) begin
        if (rst) begin
            pulse       <= 1'b0;
            sync        <= 1'b0;
            pump_on     <= 1'b1;
            att         <= '0;
            cycle_start <= 1'b0;
        end else begin
            pulse       <= pulse_nxt_s;
            sync        <= ({1'b0, cnt_r} < act_sync_end_r);
            pump_on     <= pump_r;
            att         <= att_nxt_s;
            cycle_start <= (cnt_r == '0);
        end
    end

endmodule
